slot_matrix: RTL and testbench

Parametrised successor to the fixed four-slot select/mux logic. It owns the MSX primary slot register (I/O port A8h) and the per-primary secondary slot registers at FFFFh, and it decodes each CPU memory cycle to one of up to 16 slot/subslot channels. Each channel is a request/acknowledge device port, so SDRAM-backed carts, the FDD and internal RAM all insert wait states uniformly. It sits between the CPU bus and the cartridge, FDD and RAM instances.

---
 rtl/slot_pkg.sv | 21 ++
 rtl/slot_regs.sv | 86 ++++++++
 rtl/slot_matrix.sv | 201 ++++++++++++++++++++
 tb/tb_slot_matrix.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_pkg.sv
// Shared definitions for the slot matrix.
//   CH_PER_PRIM : subslot channels per primary slot
//   MAX_CH      : total channel count (4 primaries x 4 subslots)
//   state_e     : device handshake states
//   ch_index()  : flattens (primary, subslot) to a channel number
package slot_pkg;

  localparam int unsigned CH_PER_PRIM = 4;
  localparam int unsigned MAX_CH      = 16;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StHold
  } state_e;

  function automatic logic [3:0] ch_index(input logic [1:0] prim, input logic [1:0] sub);
    return 4'(int'(prim) * CH_PER_PRIM + int'(sub));
  endfunction

endpackage

// File: rtl/slot_regs.sv
// Slot registers and page decode.
// Holds the primary slot register (I/O port PSLOT_PORT) and the secondary slot register of
// every expanded primary (memory FFFFh), and maps the current CPU address to a channel.
// Ports:
//   clk, reset_n      : clock, asynchronous active-low reset
//   clk_en            : CPU clock enable, qualifies register writes
//   addr, mreq_n,
//   iorq_n, wr_n      : CPU bus
//   d_from_cpu        : CPU write data
//   psl_q             : primary slot register
//   io_rd_data        : read value for an I/O read at the current address
//   ssl_rd_data       : read value of the selected secondary register (inverted)
//   ssl_access        : current memory cycle targets the secondary register
//   ch                : decoded channel for the current address
//   ch_exists         : decoded primary is below NUM_PRIMARY
//   ch_populated      : decoded channel exists and has a device attached
module slot_regs
  import slot_pkg::*;
#(
  parameter int unsigned       NUM_PRIMARY = 4,
  parameter logic [3:0]        EXPANDED    = 4'b0000,
  parameter logic [MAX_CH-1:0] POPULATED   = 16'h000F,
  parameter logic [7:0]        PSLOT_PORT  = 8'hA8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic [15:0] addr,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        wr_n,
  input  logic [7:0]  d_from_cpu,
  output logic [7:0]  psl_q,
  output logic [7:0]  io_rd_data,
  output logic [7:0]  ssl_rd_data,
  output logic        ssl_access,
  output logic [3:0]  ch,
  output logic        ch_exists,
  output logic        ch_populated
);

  logic [7:0] ssl_q [4];
  logic [1:0] page;
  logic [2:0] page_pos;
  logic [1:0] prim;
  logic [1:0] sub;
  logic [1:0] ssl_prim;
  logic       psl_we;
  logic       ssl_we;

  assign page     = addr[15:14];
  assign page_pos = {page, 1'b0};
  assign prim     = psl_q[page_pos +: 2];
  assign sub      = EXPANDED[prim] ? ssl_q[prim][page_pos +: 2] : 2'b00;
  assign ch       = ch_index(prim, sub);

  assign ch_exists    = 32'(prim) < NUM_PRIMARY;
  assign ch_populated = ch_exists && POPULATED[ch];

  // The secondary register seen at FFFFh belongs to whichever primary owns page 3.
  assign ssl_prim    = psl_q[7:6];
  assign ssl_access  = !mreq_n && (addr == 16'hFFFF) && EXPANDED[ssl_prim];
  assign ssl_rd_data = ~ssl_q[ssl_prim];

  assign io_rd_data = (addr[7:0] == PSLOT_PORT) ? psl_q : 8'hFF;

  assign psl_we = clk_en && !iorq_n && !wr_n && (addr[7:0] == PSLOT_PORT);
  assign ssl_we = clk_en && ssl_access && !wr_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      psl_q <= 8'h00;
      for (int p = 0; p < 4; p++) begin
        ssl_q[p] <= 8'h00;
      end
    end else begin
      if (psl_we) begin
        psl_q <= d_from_cpu;
      end
      if (ssl_we) begin
        ssl_q[ssl_prim] <= d_from_cpu;
      end
    end
  end

endmodule

// File: rtl/slot_matrix.sv
// MSX slot matrix: slot registers, channel select and request/acknowledge handshake.
// Every memory cycle is decoded to a slot/subslot channel. Populated channels get a single
// dev_rd/dev_wr request and the CPU is held in wait until the channel acknowledges or the
// wait counter expires. Unpopulated reads return FFh immediately; unpopulated writes are
// dropped.
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   clk_en                : CPU clock enable
//   addr, mreq_n, iorq_n,
//   rd_n, wr_n            : CPU bus control
//   d_from_cpu / d_to_cpu : CPU data in / out
//   wait_n                : CPU wait, low while a device access is outstanding
//   sltsl_n               : per-channel slot select, active low
//   dev_rd, dev_wr        : one-cycle request to the selected channel
//   dev_ack, dev_data     : per-channel completion and read data (channel ch at [8*ch+:8])
//   timeout_err           : one-cycle pulse when an access is aborted by the wait counter
//   psl_q                 : primary slot register
// The wait counter clears in the request cycle and counts clk_en cycles in BUSY; the access
// times out in the BUSY cycle where the count reaches TIMEOUT.
module slot_matrix
  import slot_pkg::*;
#(
  parameter int unsigned       NUM_PRIMARY = 4,
  parameter logic [3:0]        EXPANDED    = 4'b0000,
  parameter logic [MAX_CH-1:0] POPULATED   = 16'h000F,
  parameter logic [7:0]        PSLOT_PORT  = 8'hA8,
  parameter int unsigned       TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clk_en,
  input  logic [15:0]           addr,
  input  logic                  mreq_n,
  input  logic                  iorq_n,
  input  logic                  rd_n,
  input  logic                  wr_n,
  input  logic [7:0]            d_from_cpu,
  output logic [7:0]            d_to_cpu,
  output logic                  wait_n,
  output logic [MAX_CH-1:0]     sltsl_n,
  output logic                  dev_rd,
  output logic                  dev_wr,
  input  logic [MAX_CH-1:0]     dev_ack,
  input  logic [8*MAX_CH-1:0]   dev_data,
  output logic                  timeout_err,
  output logic [7:0]            psl_q
);

  localparam int unsigned    CntW    = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      ch_q;
  logic            rd_q;
  logic [7:0]      d_q;

  logic [7:0] io_rd_data;
  logic [7:0] ssl_rd_data;
  logic       ssl_access;
  logic [3:0] ch;
  logic       ch_exists;
  logic       ch_populated;

  logic       mem_cycle;
  logic       cycle_end;
  logic       start;
  logic       ack;
  logic       tmo;
  logic       latch;
  logic [6:0] data_pos;

  slot_regs #(
    .NUM_PRIMARY (NUM_PRIMARY),
    .EXPANDED    (EXPANDED),
    .POPULATED   (POPULATED),
    .PSLOT_PORT  (PSLOT_PORT)
  ) u_regs (
    .clk          (clk),
    .reset_n      (reset_n),
    .clk_en       (clk_en),
    .addr         (addr),
    .mreq_n       (mreq_n),
    .iorq_n       (iorq_n),
    .wr_n         (wr_n),
    .d_from_cpu   (d_from_cpu),
    .psl_q        (psl_q),
    .io_rd_data   (io_rd_data),
    .ssl_rd_data  (ssl_rd_data),
    .ssl_access   (ssl_access),
    .ch           (ch),
    .ch_exists    (ch_exists),
    .ch_populated (ch_populated)
  );

  assign mem_cycle = !mreq_n && (!rd_n || !wr_n);
  assign cycle_end = mreq_n || (rd_n && wr_n);

  // Only IDLE launches a request, and IDLE is reached only once the CPU cycle has ended,
  // so a strobe held low cannot retrigger. Gated by reset_n so nothing fires while in reset.
  assign start = reset_n && (state_q == StIdle) && clk_en && mem_cycle && !ssl_access &&
                 ch_populated;

  assign data_pos = {ch_q, 3'b000};
  assign ack      = dev_ack[ch_q];
  assign tmo      = clk_en && (cnt_q == CntLast);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a CPU cycle ending in BUSY aborts ahead of any ack or timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StBusy;
      end
      StBusy: begin
        if (cycle_end)      state_d = StIdle;
        else if (ack || tmo) state_d = StHold;
      end
      StHold: begin
        if (cycle_end) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs
  always_comb begin
    wait_n      = 1'b1;
    dev_rd      = 1'b0;
    dev_wr      = 1'b0;
    timeout_err = 1'b0;
    latch       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          wait_n = 1'b0;
          dev_rd = !rd_n;
          dev_wr = rd_n;
        end
      end
      StBusy: begin
        wait_n = 1'b0;
        if (!cycle_end) begin
          if (ack)      latch       = rd_q;
          else if (tmo) timeout_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Access context and read data; d_q reads FFh unless a read is acknowledged.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ch_q  <= 4'h0;
      rd_q  <= 1'b0;
      d_q   <= 8'hFF;
    end else if (start) begin
      cnt_q <= '0;
      ch_q  <= ch;
      rd_q  <= !rd_n;
      d_q   <= 8'hFF;
    end else if (state_q == StBusy) begin
      if (clk_en) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (latch) begin
        d_q <= dev_data[data_pos +: 8];
      end
    end
  end

  always_comb begin
    d_to_cpu = d_q;
    if (!iorq_n && !rd_n) begin
      d_to_cpu = io_rd_data;
    end else if (ssl_access && !rd_n) begin
      d_to_cpu = ssl_rd_data;
    end else if (mem_cycle && !rd_n && (state_q == StIdle) && !ch_populated) begin
      d_to_cpu = 8'hFF;
    end
  end

  always_comb begin
    sltsl_n = '1;
    if (reset_n && mem_cycle && !ssl_access && ch_exists) begin
      sltsl_n[ch] = 1'b0;
    end
  end

endmodule

// File: tb/tb_slot_matrix.sv
// Self-checking bench for slot_matrix: directed scenarios plus a randomized access mix
// checked against a transaction-level model of the slot registers and channel decode.
module tb_slot_matrix;

  localparam int unsigned NUM_P = 4;
  localparam logic [3:0]  EXP_P = 4'b1000;
  localparam logic [15:0] POP_P = 16'hD121;  // channels 0, 5, 8, 12, 14, 15
  localparam int unsigned TMO   = 8;
  localparam int          NCYC  = TMO + 14;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         clk_en;
  logic [15:0]  addr;
  logic         mreq_n, iorq_n, rd_n, wr_n;
  logic [7:0]   d_from_cpu;
  logic [7:0]   d_to_cpu;
  logic         wait_n;
  logic [15:0]  sltsl_n;
  logic         dev_rd, dev_wr;
  logic [15:0]  dev_ack;
  logic [127:0] dev_data;
  logic         timeout_err;
  logic [7:0]   psl_q;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_psl;
  logic [7:0] m_ssl [4];

  always #5 clk = ~clk;

  slot_matrix #(
    .NUM_PRIMARY (NUM_P),
    .EXPANDED    (EXP_P),
    .POPULATED   (POP_P),
    .PSLOT_PORT  (8'hA8),
    .TIMEOUT     (TMO)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_en      (clk_en),
    .addr        (addr),
    .mreq_n      (mreq_n),
    .iorq_n      (iorq_n),
    .rd_n        (rd_n),
    .wr_n        (wr_n),
    .d_from_cpu  (d_from_cpu),
    .d_to_cpu    (d_to_cpu),
    .wait_n      (wait_n),
    .sltsl_n     (sltsl_n),
    .dev_rd      (dev_rd),
    .dev_wr      (dev_wr),
    .dev_ack     (dev_ack),
    .dev_data    (dev_data),
    .timeout_err (timeout_err),
    .psl_q       (psl_q)
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_psl = 8'h00;
    for (int p = 0; p < 4; p++) m_ssl[p] = 8'h00;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    addr = a; iorq_n = 1'b0; wr_n = 1'b0; d_from_cpu = d;
    if (clk_en && a[7:0] == 8'hA8) m_psl = d;
    tick();
    iorq_n = 1'b1; wr_n = 1'b1;
    tick();
  endtask

  task automatic io_read(input logic [15:0] a, output logic [7:0] d);
    addr = a; iorq_n = 1'b0; rd_n = 1'b0;
    #1 d = d_to_cpu;
    tick();
    iorq_n = 1'b1; rd_n = 1'b1;
    tick();
  endtask

  // One CPU memory cycle held for NCYC clocks. ack_k is the BUSY cycle (1-based) on which the
  // selected channel acknowledges (<1 for never); spur_k drives an ack on another channel.
  task automatic mem_access(input logic [15:0] a, input bit is_rd, input logic [7:0] wd,
                            input int ack_k, input int spur_k, input string tag);
    logic [1:0]   page, prim, sub;
    int           ch, spur_ch;
    bit           acc_ssl, exists, pop;
    logic [15:0]  exp_sl, sl_seen;
    logic [7:0]   exp_d, got_d;
    int           exp_low, exp_rd, exp_wr, exp_err;
    int           low, nrd, nwr, nerr;
    bit           sl_bad;
    logic [127:0] data;

    page    = a[15:14];
    prim    = 2'(m_psl >> (2 * int'(page)));
    sub     = EXP_P[prim] ? 2'(m_ssl[prim] >> (2 * int'(page))) : 2'b00;
    ch      = int'(prim) * 4 + int'(sub);
    spur_ch = (ch + 5) % 16;
    exists  = int'(prim) < NUM_P;
    pop     = exists && POP_P[ch];
    acc_ssl = (a == 16'hFFFF) && EXP_P[m_psl[7:6]];
    data    = {$urandom, $urandom, $urandom, $urandom};

    exp_sl = 16'hFFFF; exp_low = 0; exp_rd = 0; exp_wr = 0; exp_err = 0; exp_d = 8'hFF;
    if (acc_ssl) begin
      exp_d = ~m_ssl[m_psl[7:6]];
    end else begin
      if (exists) exp_sl[ch] = 1'b0;
      if (pop) begin
        exp_rd = is_rd ? 1 : 0;
        exp_wr = is_rd ? 0 : 1;
        if (ack_k >= 1 && ack_k <= TMO) begin
          exp_low = 1 + ack_k;
          exp_d   = 8'(data >> (8 * ch));
        end else begin
          exp_low = 1 + TMO;
          exp_err = 1;
        end
      end
    end

    dev_data = data;
    addr = a; mreq_n = 1'b0; rd_n = !is_rd; wr_n = is_rd; d_from_cpu = wd;
    low = 0; nrd = 0; nwr = 0; nerr = 0; sl_bad = 1'b0; sl_seen = 16'hFFFF; got_d = 8'h00;
    for (int j = 0; j < NCYC; j++) begin
      dev_ack = '0;
      if (j == ack_k) dev_ack[ch] = 1'b1;
      if (j == spur_k) dev_ack[spur_ch] = 1'b1;
      #1;
      if (wait_n === 1'b0) low++;
      if (dev_rd === 1'b1) nrd++;
      if (dev_wr === 1'b1) nwr++;
      if (timeout_err === 1'b1) nerr++;
      if (sltsl_n !== exp_sl) begin sl_bad = 1'b1; sl_seen = sltsl_n; end
      got_d = d_to_cpu;
      tick();
    end
    dev_ack = '0; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    tick();

    if (acc_ssl && !is_rd) m_ssl[m_psl[7:6]] = wd;

    n_cmp++;
    if (low !== exp_low) begin
      n_bad++; $display("FAIL %s wait_low got %0d want %0d", tag, low, exp_low);
    end
    n_cmp++;
    if (nrd !== exp_rd) begin
      n_bad++; $display("FAIL %s dev_rd_pulses got %0d want %0d", tag, nrd, exp_rd);
    end
    n_cmp++;
    if (nwr !== exp_wr) begin
      n_bad++; $display("FAIL %s dev_wr_pulses got %0d want %0d", tag, nwr, exp_wr);
    end
    n_cmp++;
    if (nerr !== exp_err) begin
      n_bad++; $display("FAIL %s timeout_err_pulses got %0d want %0d", tag, nerr, exp_err);
    end
    n_cmp++;
    if (sl_bad) begin
      n_bad++; $display("FAIL %s sltsl_n got %h want %h", tag, sl_seen, exp_sl);
    end
    if (is_rd) begin
      n_cmp++;
      if (got_d !== exp_d) begin
        n_bad++; $display("FAIL %s d_to_cpu got %h want %h", tag, got_d, exp_d);
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    addr = 16'h0000; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    n_cmp++;
    if (sltsl_n !== 16'hFFFF) begin
      n_bad++; $display("FAIL reset_sltsl got %h want ffff", sltsl_n);
    end
    n_cmp++;
    if (wait_n !== 1'b1 || dev_rd !== 1'b0 || dev_wr !== 1'b0 || timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl got wait_n=%b rd=%b wr=%b err=%b want 1 0 0 0",
               wait_n, dev_rd, dev_wr, timeout_err);
    end
    tick();
    mreq_n = 1'b1; rd_n = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    model_reset();
    #1;
    n_cmp++;
    if (psl_q !== 8'h00) begin
      n_bad++; $display("FAIL reset_psl got %h want 00", psl_q);
    end
    n_cmp++;
    if (d_to_cpu !== 8'hFF) begin
      n_bad++; $display("FAIL reset_data got %h want ff", d_to_cpu);
    end
    tick();
  endtask

  task automatic test_basic_read();
    mem_access(16'h0000, 1'b1, 8'h00, 2, -1, "read_ch0_3wait");
    mem_access(16'h1234, 1'b0, 8'h77, 1, -1, "write_ch0");
  endtask

  task automatic test_io();
    logic [7:0] d;
    io_write(16'h00A8, 8'hC0);
    io_read(16'h00A8, d);
    n_cmp++;
    if (d !== 8'hC0) begin
      n_bad++; $display("FAIL io_read_psl got %h want c0", d);
    end
    io_read(16'h0099, d);
    n_cmp++;
    if (d !== 8'hFF) begin
      n_bad++; $display("FAIL io_read_other got %h want ff", d);
    end
    clk_en = 1'b0;
    io_write(16'h00A8, 8'h55);
    clk_en = 1'b1;
    n_cmp++;
    if (psl_q !== m_psl) begin
      n_bad++; $display("FAIL psl_no_clk_en got %h want %h", psl_q, m_psl);
    end
  endtask

  task automatic test_subslot();
    mem_access(16'hFFFF, 1'b0, 8'h24, -1, -1, "ssl_write");
    mem_access(16'hFFFF, 1'b1, 8'h00, -1, -1, "ssl_read");
    mem_access(16'hC000, 1'b1, 8'h00, 3, -1, "page3_sub");
    io_write(16'h00A8, 8'hF0);
    mem_access(16'h8000, 1'b1, 8'h00, 4, -1, "page2_ch14");
  endtask

  task automatic test_unpopulated();
    io_write(16'h00A8, 8'h04);
    mem_access(16'h4000, 1'b1, 8'h00, 2, -1, "unpop_read");
    mem_access(16'h4001, 1'b0, 8'h3C, 2, -1, "unpop_write");
  endtask

  task automatic test_timeout();
    mem_access(16'h0010, 1'b1, 8'h00, -1, -1, "timeout");
    mem_access(16'h0020, 1'b1, 8'h00, TMO, -1, "ack_at_timeout");
  endtask

  task automatic test_spurious_ack();
    mem_access(16'h0030, 1'b1, 8'h00, 5, 2, "spurious_ack");
  endtask

  task automatic test_abort();
    int nerr;
    io_write(16'h00A8, 8'h00);
    dev_data = {$urandom, $urandom, $urandom, $urandom};
    addr = 16'h0000; mreq_n = 1'b0; rd_n = 1'b0;
    tick(); tick(); tick();
    mreq_n = 1'b1; rd_n = 1'b1; dev_ack[0] = 1'b1;
    nerr = 0;
    #1 if (timeout_err === 1'b1) nerr++;
    tick();
    dev_ack = '0;
    #1;
    n_cmp++;
    if (wait_n !== 1'b1) begin
      n_bad++; $display("FAIL abort_wait got %b want 1", wait_n);
    end
    n_cmp++;
    if (d_to_cpu !== 8'hFF) begin
      n_bad++; $display("FAIL abort_no_latch got %h want ff", d_to_cpu);
    end
    for (int i = 0; i < TMO + 2; i++) begin
      tick();
      #1 if (timeout_err === 1'b1) nerr++;
    end
    n_cmp++;
    if (nerr != 0) begin
      n_bad++; $display("FAIL abort_no_error got %0d want 0", nerr);
    end
    tick();
    mem_access(16'h0000, 1'b1, 8'h00, 2, -1, "after_abort");
  endtask

  task automatic test_reset_busy();
    io_write(16'h00A8, 8'h04);
    addr = 16'h0000; mreq_n = 1'b0; rd_n = 1'b0;
    tick(); tick();
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (wait_n !== 1'b1) begin
      n_bad++; $display("FAIL reset_busy_wait got %b want 1", wait_n);
    end
    n_cmp++;
    if (psl_q !== 8'h00) begin
      n_bad++; $display("FAIL reset_busy_psl got %h want 00", psl_q);
    end
    n_cmp++;
    if (sltsl_n !== 16'hFFFF) begin
      n_bad++; $display("FAIL reset_busy_sltsl got %h want ffff", sltsl_n);
    end
    tick();
    mreq_n = 1'b1; rd_n = 1'b1;
    tick();
    reset_n = 1'b1;
    model_reset();
    tick();
    mem_access(16'h0000, 1'b1, 8'h00, 1, -1, "after_reset");
  endtask

  task automatic test_random();
    logic [15:0] a;
    int ack_k, spur_k;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        io_write(16'h00A8, 8'($urandom));
        n_cmp++;
        if (psl_q !== m_psl) begin
          n_bad++; $display("FAIL rand_psl[%0d] got %h want %h", i, psl_q, m_psl);
        end
      end
      a      = ($urandom_range(0, 5) == 0) ? 16'hFFFF : 16'($urandom);
      ack_k  = $urandom_range(1, TMO + 2);
      spur_k = ($urandom_range(0, 1) == 0) ? -1 : $urandom_range(1, 3);
      mem_access(a, 1'($urandom), 8'($urandom), ack_k, spur_k, $sformatf("rand%0d", i));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; clk_en = 1'b1; addr = 16'h0000;
    mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    d_from_cpu = 8'h00; dev_ack = '0; dev_data = '0;
    model_reset();
    tick();
    test_reset();
    test_basic_read();
    test_io();
    test_subslot();
    test_unpopulated();
    test_timeout();
    test_spurious_ack();
    test_abort();
    test_reset_busy();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
